// File: rtl/sevenseg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_arb_pkg
// Purpose  : Shared widths, FSM state encoding and reset constants for the
//            seven-segment display arbiter.
// Contents : NREQ, SRC_W, DATA_W, state_t, PTR_RST, DISP_RST
// Revision : 1.0 - initial release
// ============================================================================
package sevenseg_arb_pkg;

    localparam int NREQ   = 4;
    localparam int SRC_W  = 2;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    // ptr resets to the last index so that requester 0 is searched first.
    localparam logic [SRC_W-1:0]  PTR_RST  = 2'd3;
    localparam logic [DATA_W-1:0] DISP_RST = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/sevenseg_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotate-priority picker. Search starts at ptr+1 and
//            wraps, so ptr itself has the lowest priority.
// Ports    : pend [NREQ-1:0] in  - pending request flags
//            ptr  [SRC_W-1:0] in - index of the last requester served
//            sel  [SRC_W-1:0] out- chosen requester (0 when none pending)
//            any             out - at least one request pending
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import sevenseg_arb_pkg::*;
(
    input  logic [NREQ-1:0]  pend,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] sel,
    output logic             any
);

    logic [SRC_W-1:0] w_idx;

    // Walk offsets from farthest to nearest; the nearest pending index after
    // ptr is written last and therefore wins. Offset NREQ wraps to ptr itself.
    always_comb begin
        sel   = '0;
        w_idx = '0;
        any   = |pend;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = ptr + SRC_W'(k + 1);
            if (pend[w_idx]) begin
                sel = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sevenseg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_arbiter
// Purpose  : Shares one 4-digit seven-segment display between four
//            requesters. Each requester owns a one-entry slot filled through
//            a valid/ready handshake; a round-robin scheduler moves pending
//            slots to the display and holds each for a minimum dwell time.
// Ports    : clk                in  - system clock
//            reset_b            in  - synchronous active-low reset
//            req_valid  [3:0]   in  - per-requester offer
//            req_data   [63:0]  in  - requester i uses [16i+15:16i]
//            req_ready  [3:0]   out - slot i is empty
//            disp_value [15:0]  out - value to display driver
//            disp_src   [1:0]   out - requester currently displayed
//            disp_valid         out - a value has been loaded since reset
// Params   : DWELL_CYCLES - minimum SHOW cycles per value (1..2^24-1)
// Config   : SEVENSEG_ARB_PRIO_EN - requester 0 preempts the dwell and is
//            always chosen first; it does not move the round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_arbiter
    import sevenseg_arb_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 12_000_000
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [DATA_W-1:0]        disp_value,
    output logic [SRC_W-1:0]         disp_src,
    output logic                     disp_valid
);

    localparam int               CNT_W        = 24;
    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [NREQ-1:0]    r_pend;
    logic [DATA_W-1:0]  r_slot [NREQ];
    logic [SRC_W-1:0]   r_ptr;
    logic [SRC_W-1:0]   r_sel;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_disp_value;
    logic [SRC_W-1:0]   r_disp_src;
    logic               r_disp_valid;

    logic [SRC_W-1:0]   w_pick;
    logic               w_any;
    logic [SRC_W-1:0]   w_sel_next;
    logic               w_take;
    logic               w_dwell_done;

    rr_pick u_rr_pick (
        .pend (r_pend),
        .ptr  (r_ptr),
        .sel  (w_pick),
        .any  (w_any)
    );

    assign req_ready  = ~r_pend;
    assign disp_value = r_disp_value;
    assign disp_src   = r_disp_src;
    assign disp_valid = r_disp_valid;

    // Next-state and selection logic. w_take registers w_sel_next into r_sel
    // on the same edge that enters LOAD.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_sel_next   = w_pick;
        w_dwell_done = (r_cnt == c_dwell_last);
`ifdef SEVENSEG_ARB_PRIO_EN
        if (r_pend[0]) begin
            w_sel_next = '0;
        end
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_take       = 1'b1;
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_state_next = SHOW;
            end
            SHOW: begin
`ifdef SEVENSEG_ARB_PRIO_EN
                if (r_pend[0] || (w_dwell_done && w_any)) begin
`else
                if (w_dwell_done && w_any) begin
`endif
                    w_take       = 1'b1;
                    w_state_next = LOAD;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_pend       <= '0;
            r_ptr        <= PTR_RST;
            r_sel        <= '0;
            r_cnt        <= '0;
            r_disp_value <= DISP_RST;
            r_disp_src   <= '0;
            r_disp_valid <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            // A slot being loaded is pending, so it cannot accept this cycle.
            for (int i = 0; i < NREQ; i++) begin
                if ((r_state == LOAD) && (r_sel == SRC_W'(i))) begin
                    r_pend[i] <= 1'b0;
                end else if (req_valid[i] && !r_pend[i]) begin
                    r_pend[i] <= 1'b1;
                    r_slot[i] <= req_data[i*DATA_W +: DATA_W];
                end
            end

            if (w_take) begin
                r_sel <= w_sel_next;
            end

            case (r_state)
                LOAD: begin
                    r_disp_value <= r_slot[r_sel];
                    r_disp_src   <= r_sel;
                    r_disp_valid <= 1'b1;
                    r_cnt        <= '0;
`ifdef SEVENSEG_ARB_PRIO_EN
                    // Requester 0 is served out of band; keep the 1..3 rotation.
                    if (r_sel != '0) begin
                        r_ptr <= r_sel;
                    end
`else
                    r_ptr <= r_sel;
`endif
                end
                SHOW: begin
                    if (r_cnt != c_dwell_last) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
